// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Purpose  : Shared types and constants for the matrix-multiplier datapath.
//            Provides the accumulator FSM state type, default product
//            width / inner dimension, and width helpers used to size the
//            dot-product accumulator so that it can never overflow.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

   // Default product width (32x32 Vedic product) and inner dimension.
   localparam int MATMUL_PW = 64;
   localparam int MATMUL_K  = 4;

   // Accumulator FSM states.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_t;

   // Sum of K terms of PW bits needs PW + clog2(K) bits; K = 1 still gets
   // one guard bit so the result port is never narrower than PW + 1.
   function automatic int acc_width(input int pw, input int k);
      return pw + ((k > 1) ? $clog2(k) : 1);
   endfunction

   // Term counter width: counts 0 .. K-1, at least one bit wide.
   function automatic int cnt_width(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_accumulator
// Purpose  : Sums a stream of K unsigned products into one dot-product
//            result. Fed by the product capture buffer (d_out/done ->
//            prod_in/prod_valid); acc_done can drive the next output
//            buffer's load input.
// Ports    : clk        in   clock, rising edge
//            reset      in   synchronous active-high reset
//            start      in   begin a new dot product (aborts any partial sum)
//            prod_in    in   [PW-1:0] unsigned product term
//            prod_valid in   prod_in valid this cycle
//            acc_out    out  [AW-1:0] last completed dot product (held)
//            acc_done   out  one-cycle pulse, acc_out is new this cycle
//            busy       out  high while accumulating
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_accumulator
   import matmul_pkg::*;
#(
   parameter int PW = MATMUL_PW,
   parameter int K  = MATMUL_K,
   parameter int AW = acc_width(PW, K)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [PW-1:0] prod_in,
   input  logic          prod_valid,
   output logic [AW-1:0] acc_out,
   output logic          acc_done,
   output logic          busy
);

   localparam int             CW       = cnt_width(K);
   localparam logic [CW-1:0]  CNT_LAST = CW'(K - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   acc_state_t    state_q,    state_d;
   logic [AW-1:0] acc_q,      acc_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [AW-1:0] acc_out_q,  acc_out_d;
   logic          acc_done_q, acc_done_d;
   logic          busy_q,     busy_d;

   logic [AW-1:0] sum;

   // Single inferred adder shared by the running and terminal updates.
   assign sum = acc_q + AW'(prod_in);

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      acc_out_d  = acc_out_q;
      acc_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            // Terms arriving while idle are ignored.
            if (start) begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         ACCUM: begin
            // start takes priority: a coincident term is dropped uncounted.
            if (start) begin
               acc_d = '0;
               cnt_d = '0;
            end else if (prod_valid) begin
               if (cnt_q == CNT_LAST) begin
                  acc_out_d  = sum;
                  acc_done_d = 1'b1;
                  acc_d      = '0;
                  cnt_d      = '0;
                  state_d    = IDLE;
               end else begin
                  acc_d = sum;
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
         end
      endcase

      // busy follows the next state so it drops together with acc_done.
      busy_d = (state_d == ACCUM);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         acc_out_q  <= '0;
         acc_done_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         acc_out_q  <= acc_out_d;
         acc_done_q <= acc_done_d;
         busy_q     <= busy_d;
      end
   end

   assign acc_out  = acc_out_q;
   assign acc_done = acc_done_q;
   assign busy     = busy_q;

endmodule : dot_product_accumulator
`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_accumulator
// Purpose  : Self-checking bench for dot_product_accumulator. Two instances
//            (K = 4 and K = 1, PW = 8) share one stimulus stream; each is
//            compared every cycle against a queue-based reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_accumulator;

   logic       clk;
   logic       reset;
   logic       start;
   logic       prod_valid;
   logic [7:0] prod_in;

   logic [9:0] acc_out4;
   logic       acc_done4;
   logic       busy4;
   logic [8:0] acc_out1;
   logic       acc_done1;
   logic       busy1;

   int n_checks = 0;
   int n_errors = 0;

   dot_product_accumulator #(.PW(8), .K(4)) dut4 (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .prod_in    (prod_in),
      .prod_valid (prod_valid),
      .acc_out    (acc_out4),
      .acc_done   (acc_done4),
      .busy       (busy4)
   );

   dot_product_accumulator #(.PW(8), .K(1)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .prod_in    (prod_in),
      .prod_valid (prod_valid),
      .acc_out    (acc_out1),
      .acc_done   (acc_done1),
      .busy       (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per instance, the list of terms collected since the
   // last start; the dot product is simply the sum of that list once it
   // holds K entries.
   bit              m_active [2];
   longint unsigned m_terms  [2][$];
   longint unsigned e_out    [2];
   bit              e_done   [2];
   bit              e_busy   [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model(input int idx, input int k, input logic r, input logic s,
                        input logic v, input logic [7:0] d);
      longint unsigned total;
      e_done[idx] = 1'b0;
      if (r) begin
         m_active[idx] = 1'b0;
         m_terms[idx].delete();
         e_out[idx] = 0;
      end else if (s) begin
         m_active[idx] = 1'b1;
         m_terms[idx].delete();
      end else if (v && m_active[idx]) begin
         m_terms[idx].push_back(longint'(d));
         if (m_terms[idx].size() == k) begin
            total = 0;
            foreach (m_terms[idx][j]) total += m_terms[idx][j];
            e_out[idx]    = total;
            e_done[idx]   = 1'b1;
            m_active[idx] = 1'b0;
            m_terms[idx].delete();
         end
      end
      e_busy[idx] = m_active[idx];
   endtask

   // One clock: apply inputs, advance the models on the edge, compare 1 ns later.
   task automatic step(input logic r, input logic s, input logic v, input logic [7:0] d);
      reset = r; start = s; prod_valid = v; prod_in = d;
      @(posedge clk);
      model(0, 4, r, s, v, d);
      model(1, 1, r, s, v, d);
      #1;
      chk("k4_acc_out",  64'(acc_out4),  64'(e_out[0]));
      chk("k4_acc_done", 64'(acc_done4), 64'(e_done[0]));
      chk("k4_busy",     64'(busy4),     64'(e_busy[0]));
      chk("k1_acc_out",  64'(acc_out1),  64'(e_out[1]));
      chk("k1_acc_done", 64'(acc_done1), 64'(e_done[1]));
      chk("k1_busy",     64'(busy1),     64'(e_busy[1]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; prod_valid = 1'b0; prod_in = 8'd0;
      for (int i = 0; i < 2; i++) begin
         m_active[i] = 1'b0; e_out[i] = 0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
      end

      // Reset state.
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      chk("reset_out", 64'(acc_out4), 64'd0);
      chk("reset_busy", 64'(busy4), 64'd0);
      idle(1);

      // Basic sum: 10+20+30+40.
      step(1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'd10);
      step(1'b0, 1'b0, 1'b1, 8'd20);
      step(1'b0, 1'b0, 1'b1, 8'd30);
      step(1'b0, 1'b0, 1'b1, 8'd40);
      chk("basic_sum", 64'(acc_out4), 64'd100);
      chk("basic_done", 64'(acc_done4), 64'd1);
      chk("basic_busy_low", 64'(busy4), 64'd0);
      idle(2);

      // Max-value terms with random gaps.
      step(1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, 3));
         step(1'b0, 1'b0, 1'b1, 8'd255);
      end
      chk("max_sum", 64'(acc_out4), 64'd1020);
      idle(1);

      // Abort after two terms, then restart.
      step(1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'd5);
      step(1'b0, 1'b0, 1'b1, 8'd6);
      step(1'b0, 1'b1, 1'b0, 8'd0);
      chk("abort_out_held", 64'(acc_out4), 64'd1020);
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
      chk("abort_sum", 64'(acc_out4), 64'd10);
      idle(1);

      // start wins over a coincident term; IDLE pulses ignored.
      step(1'b0, 1'b1, 1'b1, 8'd99);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'd1);
      chk("collision_sum", 64'(acc_out4), 64'd4);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'd77);
      chk("idle_pulse_out", 64'(acc_out4), 64'd4);

      // Reset mid-operation, reset overriding start, then 4 x 7.
      step(1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'd7);
      step(1'b0, 1'b0, 1'b1, 8'd7);
      step(1'b1, 1'b0, 1'b1, 8'd7);
      chk("midreset_out", 64'(acc_out4), 64'd0);
      step(1'b1, 1'b1, 1'b0, 8'd0);
      chk("reset_over_start", 64'(busy4), 64'd0);
      step(1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'd7);
      chk("after_reset_sum", 64'(acc_out4), 64'd28);
      idle(1);

      // K = 1 back-to-back: start again in the acc_done cycle.
      step(1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'd3);
      chk("k1_first", 64'(acc_out1), 64'd3);
      chk("k1_first_done", 64'(acc_done1), 64'd1);
      step(1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'd9);
      chk("k1_second", 64'(acc_out1), 64'd9);
      chk("k1_second_done", 64'(acc_done1), 64'd1);
      idle(1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 9) == 0),
              $urandom_range(0, 2) != 0,
              8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_dot_product_accumulator
`default_nettype wire

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Accumulates a fixed-length stream of unsigned products into one dot-product result for the matrix multiplier. It sits directly downstream of the product capture buffer: the buffer's `d_out`/`done` pair drives `prod_in`/`prod_valid`. After K products it emits the sum with a one-cycle `acc_done` pulse, which can drive the `do` input of the next output buffer.

## Interface
- `PW`, default 64: product width in bits (32x32 Vedic product).
- `K`, default 4: products per dot product (matrix inner dimension); K ≥ 1.
- `AW`, default `PW + $clog2(K)` (minimum `PW + 1` when K = 1): accumulator/result width; chosen so the sum cannot overflow.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new dot product: clears the accumulator and the term counter.
- `prod_in`  in  PW  unsigned product term.
- `prod_valid`  in  1  `prod_in` is valid this cycle; one term per asserted cycle.
- `acc_out`  out  AW  last completed dot product; held until the next completion.
- `acc_done`  out  1  one-cycle pulse; `acc_out` is new this cycle.
- `busy`  out  1  high while in ACCUM.

## Operation
- **FSM states:** IDLE, ACCUM.
- **IDLE:**
  - `start` → ACCUM, with acc = 0 and cnt = 0.
  - `prod_valid` without `start` is ignored.
- **ACCUM, `prod_valid` with cnt < K-1:** acc <= acc + `prod_in` (zero-extended to AW), cnt <= cnt + 1.
- **ACCUM, `prod_valid` with cnt == K-1:**
  - `acc_out` <= acc + `prod_in`; `acc_done` <= 1.
  - acc and cnt cleared; state → IDLE.
- **ACCUM, no `prod_valid`:** hold; gaps of any length between terms are allowed.
- **`start` while in ACCUM:** abort the partial sum and restart (acc = 0, cnt = 0, stay in ACCUM). No `acc_done` is emitted and `acc_out` is unchanged.
- **`start` and `prod_valid` in the same cycle:** `start` wins and the coincident product is discarded (not counted). This holds in both states.
- **K = 1:** the first valid term after `start` completes the operation.
- **Counter:** cnt width is `$clog2(K)`, with a minimum of 1. cnt never wraps, because the terminal term returns the FSM to IDLE.
- **Arithmetic:** unsigned only; no saturation is needed given AW.

## Timing
- **Reset values:** state IDLE, acc 0, cnt 0, `acc_out` 0, `acc_done` 0, `busy` 0.
- `reset` overrides `start` and `prod_valid` in the same cycle. Reset mid-accumulation discards the partial sum.
- **Latency:** the K-th valid term sampled at edge t gives `acc_out` updated and `acc_done` = 1 in cycle t+1.
- `acc_done` is high for exactly one cycle per completed dot product.
- `busy` is registered: it rises the cycle after `start` is sampled and falls in the same cycle `acc_done` rises.
- **Throughput:** one term per cycle.
  - A new `start` may be asserted in the cycle `acc_done` is high.
  - Back-to-back dot products therefore cost K + 1 cycles each.

## Structure
- Shared package `matmul_pkg`:
  - FSM state typedef {IDLE, ACCUM}.
  - Default `PW`/`K` constants.
  - A `clog2`-based width helper for AW.
- Single flat module; no sub-module.
- The adder is inferred. The product buffer stays a separate instance at the top level.

## Test plan
- **Basic sum.** Setup: reset, PW=8, K=4. Stimulus: `start`, then `prod_valid` with 10, 20, 30, 40 on consecutive cycles. Required: `acc_out` = 100 and `acc_done` high for one cycle, exactly 1 cycle after the 40 is sampled; `busy` low in that same cycle.
- **Gaps and max values.** Stimulus: K=4, terms 255 ×4 with 0–3 idle cycles between them. Required: `acc_out` = 1020 (AW=10, no overflow); `acc_done` only after the 4th term.
- **Abort.** Stimulus: `start`, 2 terms (5, 6), then `start` again, then 1, 2, 3, 4. Required: `acc_out` = 10; only one `acc_done`; `acc_out` is unchanged at the second `start`.
- **Collisions and idle input.** Stimulus:
  - `start` with `prod_valid` = 1 carrying 99 in the same cycle, followed by 1, 1, 1, 1;
  - `prod_valid` pulses while in IDLE.

  Required: `acc_out` = 4 (the 99 is discarded); no change and no `acc_done` from the IDLE pulses.
- **Reset mid-operation.** Stimulus: assert `reset` after 2 of 4 terms, then run a full 4-term sequence of 7s. Required: all outputs 0 during reset; then `acc_out` = 28.
- **Back-to-back, K=1.** Stimulus: K=1, `start` asserted in the `acc_done` cycle, with terms 3 then 9. Required: `acc_out` = 3 then 9; two `acc_done` pulses 2 cycles apart.
